board_mem_arbiter: RTL and testbench

- Shares the single-port on-chip board/tile RAM between two requesters: the Avalon-MM slave (CPU writes of board state, palette and score) and the video fetch path (tile lookups driven by DrawX/DrawY).
- Video normally has priority.
- A starvation counter guarantees the CPU a slot at a bounded wait.
- Sits between the Avalon slave boundary and the OCM instance inside the text/graphics interface.

---
 rtl/board_mem_pkg.sv | 15 +
 rtl/arb_starve_cnt.sv | 28 ++
 rtl/board_mem_arbiter.sv | 102 ++++++++++
 tb/tb_board_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_mem_pkg.sv
// Shared constants and types for the board/tile RAM arbiter.
// Owner tags mark which requester a pending RAM read belongs to.
package board_mem_pkg;

    localparam int ADDR_W_DFLT = 12;
    localparam int DATA_W_DFLT = 32;
    localparam int RD_LAT      = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the CPU was denied the RAM.
// o_full tells the arbiter to force a CPU grant.
module arb_starve_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_full
);

    logic [7:0] r_cnt;
    logic       w_full;

    assign w_full = (r_cnt == 8'(MAX_WAIT));
    assign o_full = w_full;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && !w_full)
            r_cnt <= r_cnt + 8'd1;
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter: video fetch has priority, the Avalon CPU
// port is force-granted after MAX_WAIT consecutive denied cycles.
module board_mem_arbiter
    import board_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DFLT,
    parameter int DATA_W   = DATA_W_DFLT,
    parameter int MAX_WAIT = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                AVL_CS,
    input  logic                AVL_READ,
    input  logic                AVL_WRITE,
    input  logic [DATA_W/8-1:0] AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]   AVL_ADDR,
    input  logic [DATA_W-1:0]   AVL_WRITEDATA,
    output logic [DATA_W-1:0]   AVL_READDATA,
    output logic                AVL_READDATAVALID,
    output logic                AVL_WAITREQUEST,
    input  logic                VID_REQ,
    input  logic [ADDR_W-1:0]   VID_ADDR,
    output logic                VID_GNT,
    output logic                VID_RVALID,
    output logic [DATA_W-1:0]   VID_RDATA,
    output logic [ADDR_W-1:0]   RAM_ADDR,
    output logic [DATA_W-1:0]   RAM_WDATA,
    output logic [DATA_W/8-1:0] RAM_BYTEEN,
    output logic                RAM_WREN,
    output logic                RAM_RDEN,
    input  logic [DATA_W-1:0]   RAM_Q
);

    generate
        if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
            $error("board_mem_arbiter: MAX_WAIT must be in 1..255");
        end
    endgenerate

    logic   w_cpu_req;
    logic   w_full;
    logic   w_force;
    logic   w_vid_gnt;
    logic   w_cpu_gnt;
    owner_e w_own_in;
    owner_e w_own_out;
    owner_e r_own [RD_LAT];

    assign w_cpu_req = AVL_CS & (AVL_READ | AVL_WRITE);
    assign w_force   = w_cpu_req & w_full;

    // Grants are held off entirely while in reset so no RAM command escapes.
    assign w_vid_gnt = ~RESET & VID_REQ & ~w_force;
    assign w_cpu_gnt = ~RESET & w_cpu_req & (w_force | ~VID_REQ);

    arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_clr  (~w_cpu_req | w_cpu_gnt),
        .i_inc  (w_cpu_req & ~w_cpu_gnt),
        .o_full (w_full)
    );

    always_comb begin
        RAM_ADDR   = AVL_ADDR;
        RAM_WDATA  = AVL_WRITEDATA;
        RAM_BYTEEN = '0;
        RAM_WREN   = 1'b0;
        RAM_RDEN   = 1'b0;
        if (w_vid_gnt) begin
            RAM_ADDR = VID_ADDR;
            RAM_RDEN = 1'b1;
        end else if (w_cpu_gnt) begin
            // Read+write together is a write; the read half is dropped.
            RAM_WREN   = AVL_WRITE;
            RAM_RDEN   = ~AVL_WRITE;
            RAM_BYTEEN = AVL_WRITE ? AVL_BYTE_EN : '0;
        end
    end

    assign w_own_in = w_vid_gnt                ? OWN_VID :
                      (w_cpu_gnt & ~AVL_WRITE) ? OWN_CPU : OWN_NONE;

    // Async clear drops any read in flight so no stale valid follows reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < RD_LAT; i++) r_own[i] <= OWN_NONE;
        end else begin
            r_own[0] <= w_own_in;
            for (int i = 1; i < RD_LAT; i++) r_own[i] <= r_own[i-1];
        end
    end

    assign w_own_out         = r_own[RD_LAT-1];
    assign VID_GNT           = w_vid_gnt;
    assign AVL_WAITREQUEST   = w_cpu_req & ~w_cpu_gnt;
    assign VID_RVALID        = (w_own_out == OWN_VID);
    assign AVL_READDATAVALID = (w_own_out == OWN_CPU);
    assign VID_RDATA         = RAM_Q;
    assign AVL_READDATA      = RAM_Q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Scoreboard bench for board_mem_arbiter: shadow-memory data model, grant
// rule model with a wait counter, queues of expected read responses.
module tb_board_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MW = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          AVL_CS, AVL_READ, AVL_WRITE;
    logic [BW-1:0] AVL_BYTE_EN;
    logic [AW-1:0] AVL_ADDR;
    logic [DW-1:0] AVL_WRITEDATA;
    logic [DW-1:0] AVL_READDATA;
    logic          AVL_READDATAVALID, AVL_WAITREQUEST;
    logic          VID_REQ;
    logic [AW-1:0] VID_ADDR;
    logic          VID_GNT, VID_RVALID;
    logic [DW-1:0] VID_RDATA;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_WDATA;
    logic [BW-1:0] RAM_BYTEEN;
    logic          RAM_WREN, RAM_RDEN;
    logic [DW-1:0] RAM_Q;

    board_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .CLK(CLK), .RESET(RESET),
        .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .AVL_READDATAVALID(AVL_READDATAVALID),
        .AVL_WAITREQUEST(AVL_WAITREQUEST),
        .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_GNT(VID_GNT),
        .VID_RVALID(VID_RVALID), .VID_RDATA(VID_RDATA),
        .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_BYTEEN(RAM_BYTEEN),
        .RAM_WREN(RAM_WREN), .RAM_RDEN(RAM_RDEN), .RAM_Q(RAM_Q)
    );

    always #10 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    exp_t          qc[$];
    exp_t          qv[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] mem    [0:(1<<AW)-1];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            vid_mode = 0;   // 0 off, 1 random, 2 saturate, 3 alternate
    int            waited;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [BW-1:0] be);
        for (int b = 0; b < BW; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    // External single-port RAM: 1-cycle read latency, byte-enabled writes.
    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        RAM_Q = '0;
        forever begin
            @(posedge CLK);
            if (RAM_WREN)
                for (int b = 0; b < BW; b++)
                    if (RAM_BYTEEN[b]) mem[RAM_ADDR][8*b +: 8] = RAM_WDATA[8*b +: 8];
            if (RAM_RDEN) RAM_Q <= mem[RAM_ADDR];
        end
    end

    // Video requester: holds request until granted, records expected data at grant.
    initial begin
        bit g;
        VID_REQ = 1'b0;
        VID_ADDR = '0;
        forever begin
            @(negedge CLK);
            g = !RESET && VID_REQ && VID_GNT;
            if (g) qv.push_back('{d: shadow[VID_ADDR], due: cyc + 1});
            @(posedge CLK);
            #1;
            if (RESET) begin
                VID_REQ  = (vid_mode == 2);
                VID_ADDR = 12'h100;
            end else if (!VID_REQ || g) begin
                case (vid_mode)
                    0: VID_REQ = 1'b0;
                    1: begin
                        VID_REQ  = ($urandom_range(0, 9) < 7);
                        VID_ADDR = AW'($urandom_range(0, 511));
                    end
                    2: begin
                        VID_REQ  = 1'b1;
                        VID_ADDR = 12'h100;
                    end
                    default: begin
                        VID_REQ  = !g;
                        VID_ADDR = 12'h100;
                    end
                endcase
            end
        end
    end

    // Monitor: grant rules, RAM command, read-response scoreboard.
    initial begin
        logic m_req, m_force, m_vg, m_cg, e_wr, e_rd, ev;
        logic [AW-1:0] e_addr;
        waited = 0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                waited = 0;
                qc.delete();
                qv.delete();
            end else begin
                m_req   = AVL_CS && (AVL_READ || AVL_WRITE);
                m_force = m_req && (waited == MW);
                m_vg    = VID_REQ && !m_force;
                m_cg    = m_req && (m_force || !VID_REQ);
                chk1("vid_gnt", VID_GNT, m_vg);
                chk1("waitrequest", AVL_WAITREQUEST, m_req && !m_cg);
                e_wr   = m_cg && AVL_WRITE;
                e_rd   = m_vg || (m_cg && !AVL_WRITE);
                e_addr = m_vg ? VID_ADDR : AVL_ADDR;
                chk1("ram_wren", RAM_WREN, e_wr);
                chk1("ram_rden", RAM_RDEN, e_rd);
                if (e_wr || e_rd) chk32("ram_addr", 32'(RAM_ADDR), 32'(e_addr));
                if (e_wr) begin
                    chk32("ram_wdata", RAM_WDATA, AVL_WRITEDATA);
                    chk32("ram_byteen", 32'(RAM_BYTEEN), 32'(AVL_BYTE_EN));
                end
                chk1("both_valid", VID_RVALID && AVL_READDATAVALID, 1'b0);
                ev = (qc.size() > 0) && (qc[0].due == cyc);
                chk1("cpu_rvalid", AVL_READDATAVALID, ev);
                if (ev) begin
                    if (AVL_READDATAVALID) chk32("cpu_rdata", AVL_READDATA, qc[0].d);
                    void'(qc.pop_front());
                end
                ev = (qv.size() > 0) && (qv[0].due == cyc);
                chk1("vid_rvalid", VID_RVALID, ev);
                if (ev) begin
                    if (VID_RVALID) chk32("vid_rdata", VID_RDATA, qv[0].d);
                    void'(qv.pop_front());
                end
                waited = (m_req && !m_cg) ? waited + 1 : 0;
            end
        end
    end

    // Call at posedge+1; returns at the following posedge+1 with the bus idle.
    task automatic cpu_op(input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be, output int waits);
        int n = 0;
        bit g = 0;
        AVL_CS = 1'b1; AVL_READ = rd; AVL_WRITE = wr;
        AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        if (rd && wr) $display("note: protocol error, READ and WRITE both high at %h (treated as write)", a);
        while (!g && n < 300) begin
            @(negedge CLK);
            if (!AVL_WAITREQUEST) g = 1;
            else n++;
        end
        if (!g) begin
            checks++;
            errors++;
            $display("FAIL cpu_timeout got no grant expected grant within 300 cycles");
        end else if (wr) begin
            shadow[a] = merge(shadow[a], d, be);
        end else begin
            qc.push_back('{d: shadow[a], due: cyc + 1});
        end
        waits = n;
        @(posedge CLK);
        #1;
        AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    endtask

    initial begin
        int w;
        for (int i = 0; i < (1<<AW); i++) shadow[i] = '0;
        RESET = 1'b1;
        AVL_CS = 1'b1; AVL_READ = 1'b0; AVL_WRITE = 1'b1;
        AVL_BYTE_EN = '1; AVL_ADDR = '0; AVL_WRITEDATA = '0;
        vid_mode = 2;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk1("rst_vid_req_seen", VID_REQ, 1'b1);
        chk1("rst_vid_gnt", VID_GNT, 1'b0);
        chk1("rst_wren", RAM_WREN, 1'b0);
        chk1("rst_rden", RAM_RDEN, 1'b0);
        chk1("rst_waitreq", AVL_WAITREQUEST, 1'b1);
        chk1("rst_cpu_rvalid", AVL_READDATAVALID, 1'b0);
        chk1("rst_vid_rvalid", VID_RVALID, 1'b0);
        @(posedge CLK); #1;
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
        vid_mode = 0;
        @(posedge CLK); #1;
        RESET = 1'b0;

        // CPU-only write then read
        cpu_op(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, w); chk32("wr_nowait", 32'(w), 0);
        cpu_op(1, 0, 12'h010, 32'h0, 4'hF, w);        chk32("rd_nowait", 32'(w), 0);

        // Byte-enable merge
        cpu_op(0, 1, 12'h020, 32'h11223344, 4'hF, w);
        cpu_op(0, 1, 12'h020, 32'hAABBCCDD, 4'h5, w);
        cpu_op(1, 0, 12'h020, 32'h0, 4'hF, w);
        chk32("be_model", shadow[12'h020], 32'h11BB33DD);

        // Seed video/CPU interleave targets
        cpu_op(0, 1, 12'h100, 32'hCAFE0100, 4'hF, w);
        cpu_op(0, 1, 12'h200, 32'hBEEF0200, 4'hF, w);

        // Video saturating: CPU waits exactly MAX_WAIT cycles
        vid_mode = 2;
        repeat (3) begin @(posedge CLK); #1; end
        cpu_op(0, 1, 12'h030, 32'h00C0FFEE, 4'hF, w); chk32("force_wait", 32'(w), MW);
        repeat (3) begin @(posedge CLK); #1; end
        cpu_op(1, 0, 12'h030, 32'h0, 4'hF, w);        chk32("force_wait_rd", 32'(w), MW);

        // Alternating video/CPU reads
        vid_mode = 3;
        for (int k = 0; k < 6; k++) cpu_op(1, 0, 12'h200, 32'h0, 4'hF, w);
        vid_mode = 0;
        repeat (3) begin @(posedge CLK); #1; end

        // Read and write together: write wins, no read response
        cpu_op(1, 1, 12'h040, 32'h00000005, 4'hF, w);
        cpu_op(1, 0, 12'h040, 32'h0, 4'hF, w);

        // Reset the cycle after a CPU read grant: no valid pulse may appear
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 12'h010;
        @(negedge CLK);
        chk1("midrst_gnt", AVL_WAITREQUEST, 1'b0);
        @(posedge CLK); #1;
        RESET = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0;
        @(negedge CLK);
        chk1("midrst_cpu_rvalid", AVL_READDATAVALID, 1'b0);
        chk1("midrst_vid_rvalid", VID_RVALID, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        cpu_op(0, 1, 12'h050, 32'h12345678, 4'hF, w); chk32("post_rst_nowait", 32'(w), 0);
        cpu_op(1, 0, 12'h050, 32'h0, 4'hF, w);

        // Randomized mix against random video traffic
        vid_mode = 1;
        repeat (80) begin
            int r;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
            cpu_op(r >= 4, r < 4 || r == 9, AW'($urandom_range(0, 511)),
                   $urandom, BW'($urandom_range(0, 15)), w);
            chk1("rand_wait_bound", (w <= MW), 1'b1);
        end

        vid_mode = 0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk32("cpu_queue_drained", 32'(qc.size()), 0);
        chk32("vid_queue_drained", 32'(qv.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got still running expected finish");
        $fatal(1, "timeout");
    end

endmodule
